// File: rtl/stream_arbiter_pkg.sv
// Shared types and helpers for the packet-atomic round-robin stream arbiter.
package stream_arbiter_pkg;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_e;

    // Increment an index modulo n; correct for non-power-of-2 n.
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_pick #(
    parameter  int unsigned N = 4,
    localparam int unsigned W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] idx,
    output logic         found
);

    // Lowest request overall is the wrapped fallback; lowest at/after ptr overrides it.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx   = W'(i);
                found = 1'b1;
            end
        end
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (req[i] && (W'(i) >= ptr)) begin
                idx = W'(i);
            end
        end
    end

endmodule

// File: rtl/stream_arbiter.sv
// Packet-atomic round-robin N-to-1 AXI-Stream arbiter with a registered output stage.
module stream_arbiter
    import stream_arbiter_pkg::*;
#(
    parameter  int unsigned NUM_INPUTS = 4,
    parameter  int unsigned ID_WIDTH   = 1,
    parameter  int unsigned DATA_WIDTH = 64,
    parameter  int unsigned DEST_WIDTH = 1,
    parameter  int unsigned USER_WIDTH = 1,
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8,
    localparam int unsigned SRC_WIDTH  = $clog2(NUM_INPUTS)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_INPUTS-1:0]            s_t_valid,
    output logic [NUM_INPUTS-1:0]            s_t_ready,
    input  logic [NUM_INPUTS-1:0]            s_t_last,
    input  logic [NUM_INPUTS*ID_WIDTH-1:0]   s_t_id,
    input  logic [NUM_INPUTS*DEST_WIDTH-1:0] s_t_dest,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0] s_t_data,
    input  logic [NUM_INPUTS*STRB_WIDTH-1:0] s_t_strb,
    input  logic [NUM_INPUTS*STRB_WIDTH-1:0] s_t_keep,
    input  logic [NUM_INPUTS*USER_WIDTH-1:0] s_t_user,
    output logic                             m_t_valid,
    input  logic                             m_t_ready,
    output logic [ID_WIDTH-1:0]              m_t_id,
    output logic [DEST_WIDTH-1:0]            m_t_dest,
    output logic [DATA_WIDTH-1:0]            m_t_data,
    output logic [STRB_WIDTH-1:0]            m_t_strb,
    output logic [STRB_WIDTH-1:0]            m_t_keep,
    output logic                             m_t_last,
    output logic [USER_WIDTH-1:0]            m_t_user,
    output logic [SRC_WIDTH-1:0]             m_src
);

    typedef struct packed {
        logic [ID_WIDTH-1:0]   id;
        logic [DEST_WIDTH-1:0] dest;
        logic [DATA_WIDTH-1:0] data;
        logic [STRB_WIDTH-1:0] strb;
        logic [STRB_WIDTH-1:0] keep;
        logic                  last;
        logic [USER_WIDTH-1:0] user;
    } beat_t;

    lock_e                state;
    logic [SRC_WIDTH-1:0] grant;
    logic [SRC_WIDTH-1:0] ptr;
    logic [SRC_WIDTH-1:0] pick_idx;
    logic [SRC_WIDTH-1:0] src;
    logic [SRC_WIDTH-1:0] src_q;
    logic                 found;
    logic                 out_full;
    logic                 can_take;
    logic                 src_valid;
    logic                 accept;
    beat_t                in_beat;
    beat_t                out_beat;
    beat_t                lane [NUM_INPUTS];

    // Unpack the flattened slave buses into one beat per input.
    for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_lane
        assign lane[i] = '{
            id:   s_t_id[i*ID_WIDTH +: ID_WIDTH],
            dest: s_t_dest[i*DEST_WIDTH +: DEST_WIDTH],
            data: s_t_data[i*DATA_WIDTH +: DATA_WIDTH],
            strb: s_t_strb[i*STRB_WIDTH +: STRB_WIDTH],
            keep: s_t_keep[i*STRB_WIDTH +: STRB_WIDTH],
            last: s_t_last[i],
            user: s_t_user[i*USER_WIDTH +: USER_WIDTH]
        };
    end

    rr_pick #(
        .N (NUM_INPUTS)
    ) u_pick (
        .req   (s_t_valid),
        .ptr   (ptr),
        .idx   (pick_idx),
        .found (found)
    );

    // Source selection and slave readies; a locked grant ignores other inputs.
    always_comb begin
        s_t_ready = '0;
        can_take  = !out_full || m_t_ready;
        src       = (state == LOCKED) ? grant : pick_idx;
        src_valid = (state == LOCKED) ? s_t_valid[src] : found;
        in_beat   = lane[src];
        if (!rst && ((state == LOCKED) || found)) begin
            s_t_ready[src] = can_take;
        end
        accept = !rst && src_valid && can_take;
    end

    // Lock state, round-robin pointer and the output beat register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= UNLOCKED;
            grant    <= '0;
            ptr      <= '0;
            out_full <= 1'b0;
            out_beat <= '0;
            src_q    <= '0;
        end else if (accept) begin
            out_full <= 1'b1;
            out_beat <= in_beat;
            src_q    <= src;
            if (in_beat.last) begin
                state <= UNLOCKED;
                ptr   <= SRC_WIDTH'(wrap_inc(32'(src), NUM_INPUTS));
            end else begin
                state <= LOCKED;
                grant <= src;
            end
        end else if (m_t_ready) begin
            out_full <= 1'b0;
        end
    end

    assign m_t_valid = out_full;
    assign m_t_id    = out_beat.id;
    assign m_t_dest  = out_beat.dest;
    assign m_t_data  = out_beat.data;
    assign m_t_strb  = out_beat.strb;
    assign m_t_keep  = out_beat.keep;
    assign m_t_last  = out_beat.last;
    assign m_t_user  = out_beat.user;
    assign m_src     = src_q;

endmodule

// File: tb/tb_stream_arbiter.sv
// Self-checking bench for stream_arbiter: a 4-input instance with a scoreboard and a 3-input instance for pointer wrap.
`timescale 1ns/1ps
module tb_stream_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // 4-input instance
    logic [3:0]   s_t_valid, s_t_ready, s_t_last;
    logic [3:0]   s_t_id, s_t_dest, s_t_user;
    logic [255:0] s_t_data;
    logic [31:0]  s_t_strb, s_t_keep;
    logic         m_t_valid, m_t_ready, m_t_id, m_t_dest, m_t_last, m_t_user;
    logic [63:0]  m_t_data;
    logic [7:0]   m_t_strb, m_t_keep;
    logic [1:0]   m_src;

    // 3-input instance
    logic [2:0]   v3, r3, l3, id3, dest3, user3;
    logic [191:0] d3;
    logic [23:0]  strb3, keep3;
    logic         mv3, mr3, mid3, mdest3, ml3, muser3;
    logic [63:0]  md3;
    logic [7:0]   mstrb3, mkeep3;
    logic [1:0]   ms3;

    stream_arbiter #(.NUM_INPUTS(4)) dut (
        .clk(clk), .rst(rst),
        .s_t_valid(s_t_valid), .s_t_ready(s_t_ready), .s_t_last(s_t_last),
        .s_t_id(s_t_id), .s_t_dest(s_t_dest), .s_t_data(s_t_data),
        .s_t_strb(s_t_strb), .s_t_keep(s_t_keep), .s_t_user(s_t_user),
        .m_t_valid(m_t_valid), .m_t_ready(m_t_ready), .m_t_id(m_t_id),
        .m_t_dest(m_t_dest), .m_t_data(m_t_data), .m_t_strb(m_t_strb),
        .m_t_keep(m_t_keep), .m_t_last(m_t_last), .m_t_user(m_t_user),
        .m_src(m_src)
    );

    stream_arbiter #(.NUM_INPUTS(3)) dut3 (
        .clk(clk), .rst(rst),
        .s_t_valid(v3), .s_t_ready(r3), .s_t_last(l3),
        .s_t_id(id3), .s_t_dest(dest3), .s_t_data(d3),
        .s_t_strb(strb3), .s_t_keep(keep3), .s_t_user(user3),
        .m_t_valid(mv3), .m_t_ready(mr3), .m_t_id(mid3),
        .m_t_dest(mdest3), .m_t_data(md3), .m_t_strb(mstrb3),
        .m_t_keep(mkeep3), .m_t_last(ml3), .m_t_user(muser3),
        .m_src(ms3)
    );

    typedef struct packed {
        logic [1:0]  src;
        logic [63:0] data;
        logic        last;
    } beat_t;

    typedef struct packed {
        logic [3:0] v;
        logic       mr;
        logic [3:0] rdy;
        logic       mv;
        logic [1:0] src;
    } vec_t;

    beat_t sb[$];
    beat_t pq[4][$];
    beat_t olog[$];
    int    ocyc[$];
    int    cyc = 0;
    int    errors = 0;
    int    checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [3:0] qmask();
        logic [3:0] m;
        m = '0;
        for (int i = 0; i < 4; i++) m[i] = (pq[i].size() > 0);
        return m;
    endfunction

    function automatic beat_t mk(input int src, input logic [63:0] data, input logic last);
        beat_t b;
        b.src  = 2'(src);
        b.data = data;
        b.last = last;
        return b;
    endfunction

    // Drive one cycle's inputs at the falling edge, then score any output handshake.
    task automatic drive(input logic [3:0] vmask, input logic mr);
        beat_t got, e;
        for (int i = 0; i < 4; i++) begin
            s_t_valid[i] = vmask[i];
            if (pq[i].size() > 0) begin
                s_t_data[i*64 +: 64] = pq[i][0].data;
                s_t_last[i]          = pq[i][0].last;
            end else begin
                s_t_data[i*64 +: 64] = 64'h100 + 64'(i);
                s_t_last[i]          = 1'b1;
            end
        end
        m_t_ready = mr;
        #1;
        if (m_t_valid && m_t_ready) begin
            got.src  = m_src;
            got.data = m_t_data;
            got.last = m_t_last;
            olog.push_back(got);
            ocyc.push_back(cyc);
            chk("sb_has_entry", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("sb_src", 64'(got.src), 64'(e.src));
                chk("sb_data", got.data, e.data);
                chk("sb_last", 64'(got.last), 64'(e.last));
            end
        end
    endtask

    // Record accepted beats as expected outputs, then advance to the next falling edge.
    task automatic commit();
        beat_t e;
        for (int i = 0; i < 4; i++) begin
            if (s_t_valid[i] && s_t_ready[i]) begin
                e.src  = 2'(i);
                e.data = s_t_data[i*64 +: 64];
                e.last = s_t_last[i];
                sb.push_back(e);
                if (pq[i].size() > 0) void'(pq[i].pop_front());
            end
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic run_until_idle(input string name);
        int c;
        c = 0;
        while ((qmask() != 4'd0 || sb.size() != 0 || m_t_valid) && c < 100) begin
            drive(qmask(), 1'b1);
            commit();
            c++;
        end
        chk({name, "_timeout"}, 64'(c < 100), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl [15];
        int          start, c;
        logic [7:0]  pat;
        logic        full_m, exp_rdy, acc, stall, prev_stall;
        logic [63:0] prev_data;

        tbl[0]  = {4'hF,    1'b1, 4'b0001, 1'b0, 2'd0};
        tbl[1]  = {4'hF,    1'b1, 4'b0010, 1'b1, 2'd0};
        tbl[2]  = {4'hF,    1'b1, 4'b0100, 1'b1, 2'd1};
        tbl[3]  = {4'hF,    1'b1, 4'b1000, 1'b1, 2'd2};
        tbl[4]  = {4'hF,    1'b1, 4'b0001, 1'b1, 2'd3};
        tbl[5]  = {4'hF,    1'b1, 4'b0010, 1'b1, 2'd0};
        tbl[6]  = {4'h0,    1'b1, 4'b0000, 1'b1, 2'd1};
        tbl[7]  = {4'h0,    1'b1, 4'b0000, 1'b0, 2'd0};
        tbl[8]  = {4'b1001, 1'b1, 4'b1000, 1'b0, 2'd0};
        tbl[9]  = {4'b1001, 1'b0, 4'b0000, 1'b1, 2'd3};
        tbl[10] = {4'b1001, 1'b1, 4'b0001, 1'b1, 2'd3};
        tbl[11] = {4'b1001, 1'b1, 4'b1000, 1'b1, 2'd0};
        tbl[12] = {4'h0,    1'b0, 4'b0000, 1'b1, 2'd3};
        tbl[13] = {4'h0,    1'b1, 4'b0000, 1'b1, 2'd3};
        tbl[14] = {4'h0,    1'b1, 4'b0000, 1'b0, 2'd0};

        rst = 1'b1;
        s_t_valid = '0; s_t_last = '0; s_t_id = '0; s_t_dest = '0; s_t_user = '0;
        s_t_data = '0; s_t_strb = '1; s_t_keep = '1; m_t_ready = 1'b0;
        v3 = '0; l3 = '0; id3 = '0; dest3 = '0; user3 = '0; d3 = '0;
        strb3 = '1; keep3 = '1; mr3 = 1'b1;

        // Reset state, with all inputs requesting
        repeat (2) @(negedge clk);
        s_t_valid = 4'hF;
        #1;
        chk("rst_m_valid", 64'(m_t_valid), 64'd0);
        chk("rst_m_data", m_t_data, 64'd0);
        chk("rst_m_src", 64'(m_src), 64'd0);
        chk("rst_s_ready", 64'(s_t_ready), 64'd0);
        chk("rst_m_valid3", 64'(mv3), 64'd0);
        s_t_valid = '0;
        rst = 1'b0;
        @(negedge clk);
        cyc++;

        // Round-robin and basic backpressure, one-beat packets
        for (int k = 0; k < 15; k++) begin
            drive(tbl[k].v, tbl[k].mr);
            chk($sformatf("tbl%0d_ready", k), 64'(s_t_ready), 64'(tbl[k].rdy));
            chk($sformatf("tbl%0d_m_valid", k), 64'(m_t_valid), 64'(tbl[k].mv));
            if (tbl[k].mv) chk($sformatf("tbl%0d_m_src", k), 64'(m_src), 64'(tbl[k].src));
            commit();
        end

        // Single input: 3-beat packet on input 2
        pq[2].push_back(mk(2, 64'hA, 1'b0));
        pq[2].push_back(mk(2, 64'hB, 1'b0));
        pq[2].push_back(mk(2, 64'hC, 1'b1));
        olog.delete(); ocyc.delete();
        start = cyc;
        run_until_idle("single");
        chk("single_count", 64'(olog.size()), 64'd3);
        for (int k = 0; k < 3; k++) begin
            if (k < olog.size()) begin
                chk($sformatf("single_data%0d", k), olog[k].data, 64'hA + 64'(k));
                chk($sformatf("single_src%0d", k), 64'(olog[k].src), 64'd2);
                chk($sformatf("single_last%0d", k), 64'(olog[k].last), 64'(k == 2));
                chk($sformatf("single_cycle%0d", k), 64'(ocyc[k] - start), 64'(k + 1));
            end
        end

        // Atomicity: inputs 0 and 1 with 4-beat packets
        for (int k = 0; k < 4; k++) begin
            pq[0].push_back(mk(0, 64'h00 + 64'(k), 1'(k == 3)));
            pq[1].push_back(mk(1, 64'h10 + 64'(k), 1'(k == 3)));
        end
        olog.delete(); ocyc.delete();
        c = 0;
        while ((qmask() != 4'd0 || sb.size() != 0 || m_t_valid) && c < 100) begin
            drive(qmask(), 1'b1);
            if (pq[0].size() > 0) chk("atom_ready1_low", 64'(s_t_ready[1]), 64'd0);
            commit();
            c++;
        end
        chk("atom_timeout", 64'(c < 100), 64'd1);
        chk("atom_count", 64'(olog.size()), 64'd8);
        for (int k = 0; k < 8; k++) begin
            if (k < olog.size()) chk($sformatf("atom_src%0d", k), 64'(olog[k].src), (k < 4) ? 64'd0 : 64'd1);
        end
        if (olog.size() == 8) chk("atom_no_bubble", 64'(ocyc[7] - ocyc[0]), 64'd7);

        // Backpressure during a 5-beat packet on input 3
        for (int k = 0; k < 5; k++) pq[3].push_back(mk(3, 64'h30 + 64'(k), 1'(k == 4)));
        olog.delete(); ocyc.delete();
        pat = 8'b1101_1001;
        full_m = 1'b0;
        prev_stall = 1'b0;
        prev_data = '0;
        c = 0;
        while ((qmask() != 4'd0 || sb.size() != 0) && c < 60) begin
            exp_rdy = !(full_m && !((c < 8) ? pat[c] : 1'b1));
            drive(qmask(), (c < 8) ? pat[c] : 1'b1);
            chk("bp_m_valid", 64'(m_t_valid), 64'(full_m));
            if (prev_stall) chk("bp_hold_data", m_t_data, prev_data);
            if (pq[3].size() > 0) chk("bp_ready", 64'(s_t_ready[3]), 64'(exp_rdy));
            acc = (pq[3].size() > 0) && exp_rdy;
            stall = full_m && !m_t_ready;
            prev_stall = stall;
            prev_data = m_t_data;
            commit();
            full_m = acc || stall;
            c++;
        end
        chk("bp_timeout", 64'(c < 60), 64'd1);
        chk("bp_count", 64'(olog.size()), 64'd5);

        // Reset mid-packet: move ptr to 3, start a 4-beat packet on input 1, reset after 2 beats
        pq[2].push_back(mk(2, 64'h200, 1'b1));
        run_until_idle("pre_rst");
        for (int k = 0; k < 4; k++) pq[1].push_back(mk(1, 64'h40 + 64'(k), 1'(k == 3)));
        for (int k = 0; k < 2; k++) begin
            drive(qmask(), 1'b1);
            commit();
        end
        chk("pre_rst_m_valid", 64'(m_t_valid), 64'd1);
        rst = 1'b1;
        #1;
        chk("rst_async_m_valid", 64'(m_t_valid), 64'd0);
        chk("rst_async_ready", 64'(s_t_ready), 64'd0);
        sb.delete();
        pq[1].delete();
        s_t_valid = '0;
        @(negedge clk);
        cyc++;
        rst = 1'b0;
        pq[3].push_back(mk(3, 64'h300, 1'b1));
        olog.delete(); ocyc.delete();
        drive(4'b1000, 1'b1);
        chk("post_rst_lock_clear", 64'(s_t_ready), 64'b1000);
        s_t_valid = 4'b1001;
        #1;
        chk("post_rst_ptr_zero", 64'(s_t_ready), 64'b0001);
        s_t_valid = 4'b1000;
        #1;
        commit();
        run_until_idle("post_rst");
        chk("post_rst_count", 64'(olog.size()), 64'd1);
        if (olog.size() > 0) chk("post_rst_src", 64'(olog[0].src), 64'd3);

        // Pointer wrap on the 3-input instance
        d3 = {64'h32, 64'h31, 64'h30};
        l3 = 3'b111;
        v3 = 3'b010;
        #1;
        chk("wrap_ready_a", 64'(r3), 64'b010);
        @(negedge clk);
        v3 = 3'b101;
        #1;
        chk("wrap_ready_b", 64'(r3), 64'b100);
        chk("wrap_src_a", 64'(ms3), 64'd1);
        @(negedge clk);
        #1;
        chk("wrap_ready_c", 64'(r3), 64'b001);
        chk("wrap_src_b", 64'(ms3), 64'd2);
        chk("wrap_data_b", md3, 64'h32);
        @(negedge clk);
        v3 = 3'b011;
        #1;
        chk("wrap_ptr_one", 64'(r3), 64'b010);
        chk("wrap_src_c", 64'(ms3), 64'd0);
        @(negedge clk);
        v3 = 3'b000;
        #1;
        chk("wrap_valid_d", 64'(mv3), 64'd1);
        chk("wrap_src_d", 64'(ms3), 64'd1);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
